freq_meas_ctrl: RTL and testbench

//  Equal-precision (reciprocal) gate sequencer for the frequency counter. Opens the measurement gate
//  on a sig_in rising edge, counts sig_in periods and sys_clk cycles for at least GATE_CYCLES, closes
//  on the next sig_in rising edge, then publishes both counts with a calc_flag strobe to the SPI readout.
//  Fin = F_sys * test_cnt / std_cnt.

---
 rtl/freq_pkg.sv | 18 +
 rtl/freq_meas_ctrl_edge_sync.sv | 34 +++
 rtl/freq_meas_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants and FSM encoding for the reciprocal frequency counter (gate sequencer
// and SPI readout side).
package freq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GATE = 3'd2,
    DONE = 3'd3,
    FLAG = 3'd4
  } state_t;

  localparam int CNT_W_DEF          = 28;
  localparam int GATE_CYCLES_DEF    = 27_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 54_000_000;
  localparam int SYS_CLK_HZ         = 27_000_000;

endpackage

// File: rtl/freq_meas_ctrl_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for an input asynchronous to clk.
// The same block serves the signal-under-test and reference-input channels.
module freq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic prev_q, prev_d;

  always_comb begin
    s0_d   = async_in;
    s1_d   = s0_q;
    prev_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s1_q & ~prev_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Equal-precision gate sequencer: gate opens and closes on sig_in rising edges, counting
// sig_in periods and sys_clk cycles. Optional no-edge timeout enabled by FREQ_TIMEOUT_EN.
module freq_meas_ctrl
  import freq_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int GATE_CYCLES    = GATE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] test_cnt,
  output logic [CNT_W-1:0] std_cnt,
  output logic             ovf,
  output logic             timeout,
  output logic             calc_flag
);

  localparam int                GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_MIN = GATE_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic rise;

  freq_edge_sync u_sync (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .async_in (sig_in),
    .rise     (rise)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   std_i_q, std_i_d;
  logic [CNT_W-1:0]   test_i_q, test_i_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic               ovf_i_q, ovf_i_d;
  logic [CNT_W-1:0]   test_cnt_q, test_cnt_d;
  logic [CNT_W-1:0]   std_cnt_q, std_cnt_d;
  logic               ovf_q, ovf_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               calc_flag_q, calc_flag_d;
  logic               abort;

`ifdef FREQ_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    std_i_d    = std_i_q;
    test_i_d   = test_i_q;
    gate_d     = gate_q;
    ovf_i_d    = ovf_i_q;
    test_cnt_d = test_cnt_q;
    std_cnt_d  = std_cnt_q;
    ovf_d      = ovf_q;
    timeout_d  = timeout_q;
    abort      = 1'b0;
`ifdef FREQ_TIMEOUT_EN
    wait_d     = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
`ifdef FREQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      ARM: begin
`ifdef FREQ_TIMEOUT_EN
        wait_d = wait_q + 1'b1;
        abort  = (wait_q == WAIT_LAST);
`endif
        // A real edge beats a timeout landing in the same cycle
        if (rise) begin
          state_d  = GATE;
          std_i_d  = CNT_W'(1);
          gate_d   = GATE_W'(1);
          test_i_d = '0;
          ovf_i_d  = 1'b0;
          abort    = 1'b0;
`ifdef FREQ_TIMEOUT_EN
          wait_d   = '0;
`endif
        end
      end
      GATE: begin
        if (rise && (gate_q >= GATE_MIN)) begin
          // Closing edge ends the last period: count it, but not this sys_clk cycle
          state_d    = DONE;
          test_cnt_d = sat_inc(test_i_q);
          std_cnt_d  = std_i_q;
          ovf_d      = ovf_i_q | (test_i_q == CNT_MAX);
          timeout_d  = 1'b0;
        end else begin
          std_i_d = sat_inc(std_i_q);
          gate_d  = (gate_q >= GATE_MIN) ? GATE_MIN : gate_q + 1'b1;
          if (std_i_q == CNT_MAX) ovf_i_d = 1'b1;
          if (rise) begin
            test_i_d = sat_inc(test_i_q);
            if (test_i_q == CNT_MAX) ovf_i_d = 1'b1;
          end
`ifdef FREQ_TIMEOUT_EN
          if (gate_q >= GATE_MIN) begin
            wait_d = wait_q + 1'b1;
            abort  = (wait_q == WAIT_LAST);
          end
`endif
        end
      end
      DONE: state_d = FLAG;
      FLAG: begin
        state_d = cont ? ARM : IDLE;
`ifdef FREQ_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = DONE;
      test_cnt_d = '0;
      std_cnt_d  = '0;
      ovf_d      = 1'b0;
      timeout_d  = 1'b1;
    end

    busy_d      = (state_d != IDLE);
    calc_flag_d = (state_d == FLAG);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      std_i_q     <= '0;
      test_i_q    <= '0;
      gate_q      <= '0;
      ovf_i_q     <= 1'b0;
      test_cnt_q  <= '0;
      std_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      calc_flag_q <= 1'b0;
`ifdef FREQ_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      std_i_q     <= std_i_d;
      test_i_q    <= test_i_d;
      gate_q      <= gate_d;
      ovf_i_q     <= ovf_i_d;
      test_cnt_q  <= test_cnt_d;
      std_cnt_q   <= std_cnt_d;
      ovf_q       <= ovf_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      calc_flag_q <= calc_flag_d;
`ifdef FREQ_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign test_cnt  = test_cnt_q;
  assign std_cnt   = std_cnt_q;
  assign ovf       = ovf_q;
  assign timeout   = timeout_q;
  assign calc_flag = calc_flag_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench for freq_meas_ctrl: a 28-bit instance (GATE=100, TIMEOUT=300) and a
// 6-bit instance for saturation. Timeout expectations follow FREQ_TIMEOUT_EN.
module tb_freq_meas_ctrl;

  typedef struct packed {
    logic [27:0] t;
    logic [27:0] s;
    logic        o;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_a = 1'b0, start_a = 1'b0, cont_a = 1'b0;
  logic        sig_b = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic        busy_a, ovf_a, tmo_a, flag_a;
  logic [27:0] test_a, std_a;
  logic        busy_b, ovf_b, tmo_b, flag_b;
  logic [5:0]  test_b, std_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   vectors = 0;
  int   errors  = 0;
  int   flags_a = 0;
  int   flags_b = 0;
  int   per_a   = 0;
  int   per_b   = 0;

  always #5 clk = ~clk;

  freq_meas_ctrl #(.CNT_W(28), .GATE_CYCLES(100), .TIMEOUT_CYCLES(300)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .sig_in(sig_a), .start(start_a), .cont(cont_a),
    .busy(busy_a), .test_cnt(test_a), .std_cnt(std_a), .ovf(ovf_a), .timeout(tmo_a),
    .calc_flag(flag_a)
  );

  freq_meas_ctrl #(.CNT_W(6), .GATE_CYCLES(100), .TIMEOUT_CYCLES(300)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .sig_in(sig_b), .start(start_b), .cont(cont_b),
    .busy(busy_b), .test_cnt(test_b), .std_cnt(std_b), .ovf(ovf_b), .timeout(tmo_b),
    .calc_flag(flag_b)
  );

  function automatic exp_t mk(input int t, input int s, input bit o, input bit to);
    exp_t e;
    e.t  = 28'(t);
    e.s  = 28'(s);
    e.o  = o;
    e.to = to;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
  endtask

  task automatic wait_flags(input bit on_b, input int target, input int budget, input string name);
    int n = 0;
    while (((on_b ? flags_b : flags_a) < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if ((on_b ? flags_b : flags_a) < target) begin
      vectors++;
      errors++;
      $display("FAIL %s: no calc_flag within %0d cycles (flags seen %0d, want %0d)",
               name, budget, on_b ? flags_b : flags_a, target);
    end
  endtask

  initial begin
    int base;
    int n;
    fork
      forever begin : gen_a
        int ph = 0;
        @(negedge clk);
        if (per_a == 0) begin
          sig_a = 1'b0;
          ph = 0;
        end else begin
          if (ph >= per_a) ph = 0;
          sig_a = (ph < per_a / 2);
          ph++;
        end
      end
      forever begin : gen_b
        int ph = 0;
        @(negedge clk);
        if (per_b == 0) begin
          sig_b = 1'b0;
          ph = 0;
        end else begin
          if (ph >= per_b) ph = 0;
          sig_b = (ph < per_b / 2);
          ph++;
        end
      end
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (flag_a === 1'b1) begin
            flags_a++;
            vectors++;
            if (exp_a.size() == 0) begin
              errors++;
              $display("FAIL flag_a_unexpected: calc_flag with test=%0d std=%0d, none expected",
                       test_a, std_a);
            end else begin
              e = exp_a.pop_front();
              if (test_a !== e.t || std_a !== e.s || ovf_a !== e.o || tmo_a !== e.to) begin
                errors++;
                $display("FAIL result_a: got test=%0d std=%0d ovf=%0b tmo=%0b, want test=%0d std=%0d ovf=%0b tmo=%0b",
                         test_a, std_a, ovf_a, tmo_a, e.t, e.s, e.o, e.to);
              end
            end
          end
          if (flag_b === 1'b1) begin
            flags_b++;
            vectors++;
            if (exp_b.size() == 0) begin
              errors++;
              $display("FAIL flag_b_unexpected: calc_flag with test=%0d std=%0d, none expected",
                       test_b, std_b);
            end else begin
              e = exp_b.pop_front();
              if ({22'd0, test_b} !== e.t || {22'd0, std_b} !== e.s || ovf_b !== e.o || tmo_b !== e.to) begin
                errors++;
                $display("FAIL result_b: got test=%0d std=%0d ovf=%0b tmo=%0b, want test=%0d std=%0d ovf=%0b tmo=%0b",
                         test_b, std_b, ovf_b, tmo_b, e.t, e.s, e.o, e.to);
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_test", test_a, 0);
    chk("rst_std", std_a, 0);
    chk("rst_ovf", {31'd0, ovf_a}, 0);
    chk("rst_timeout", {31'd0, tmo_a}, 0);
    chk("rst_flag", {31'd0, flag_a}, 0);
    rst_n = 1'b1;

    // 1: period 10, single shot
    per_a = 10;
    repeat (20) @(negedge clk);
    base = flags_a;
    exp_a.push_back(mk(10, 100, 1'b0, 1'b0));
    pulse_a();
    chk("t1_busy_after_start", {31'd0, busy_a}, 1);
    wait_flags(1'b0, base + 1, 400, "t1_flag");
    repeat (5) @(negedge clk);
    chk("t1_busy_idle", {31'd0, busy_a}, 0);
    repeat (150) @(negedge clk);

    // 2: period 7, closes at 105 cycles
    per_a = 7;
    repeat (20) @(negedge clk);
    base = flags_a;
    exp_a.push_back(mk(15, 105, 1'b0, 1'b0));
    pulse_a();
    wait_flags(1'b0, base + 1, 400, "t2_flag");
    repeat (20) @(negedge clk);

    // 3: continuous mode, three results
    per_a = 10;
    repeat (20) @(negedge clk);
    base = flags_a;
    repeat (3) exp_a.push_back(mk(10, 100, 1'b0, 1'b0));
    cont_a = 1'b1;
    pulse_a();
    wait_flags(1'b0, base + 2, 800, "t3_flag2");
    repeat (5) @(negedge clk);
    cont_a = 1'b0;
    wait_flags(1'b0, base + 3, 400, "t3_flag3");
    repeat (20) @(negedge clk);
    chk("t3_busy_idle", {31'd0, busy_a}, 0);
    chk("t3_test_held", test_a, 10);
    repeat (150) @(negedge clk);

    // 4: reset mid-gate discards the measurement
    pulse_a();
    repeat (50) @(negedge clk);
    chk("t4_busy_in_gate", {31'd0, busy_a}, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_rst_busy", {31'd0, busy_a}, 0);
    chk("t4_rst_test", test_a, 0);
    chk("t4_rst_std", std_a, 0);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    base = flags_a;
    exp_a.push_back(mk(10, 100, 1'b0, 1'b0));
    pulse_a();
    wait_flags(1'b0, base + 1, 400, "t4_flag");
    repeat (20) @(negedge clk);

    // 5: sig_in stuck low
    per_a = 0;
    repeat (10) @(negedge clk);
`ifdef FREQ_TIMEOUT_EN
    exp_a.push_back(mk(0, 0, 1'b0, 1'b1));
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    n = 1;
    while (flag_a !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t5_timeout_latency", n, 302);
    repeat (5) @(negedge clk);
    chk("t5_busy_idle", {31'd0, busy_a}, 0);
`else
    pulse_a();
    repeat (400) @(negedge clk);
    chk("t5_busy_stuck", {31'd0, busy_a}, 1);
    chk("t5_timeout_tied", {31'd0, tmo_a}, 0);
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 6: 6-bit counters saturate, extra starts ignored
    per_b = 10;
    repeat (20) @(negedge clk);
    base = flags_b;
    exp_b.push_back(mk(10, 63, 1'b1, 1'b0));
    pulse_b();
    repeat (40) @(negedge clk);
    pulse_b();
    repeat (10) @(negedge clk);
    pulse_b();
    chk("t6_busy_in_gate", {31'd0, busy_b}, 1);
    wait_flags(1'b1, base + 1, 400, "t6_flag");
    repeat (150) @(negedge clk);
    chk("t6_busy_idle", {31'd0, busy_b}, 0);

    chk("pending_a", exp_a.size(), 0);
    chk("pending_b", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
